emib_ram_responder: RTL

Memory-side responder for the EMIB shared RAM. It sits between the bus arbiter's RAM port (read/write address, write data, read/write enables) and the storage array, and returns read data with the one-clock latency the arbiter's output capture depends on. It also zero-fills the RAM after reset, counts requests dropped before fill completes, and optionally adds per-word parity with error reporting.

---
 rtl/emib_pkg.sv | 23 ++
 rtl/emib_ram_array.sv | 31 +++
 rtl/emib_ram_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/emib_pkg.sv
// Shared types and constants for the EMIB shared-RAM responder.
// Default widths match the global EMIB address/data widths.
package emib_pkg;

  localparam int EMIB_ADDR_W = 12;
  localparam int EMIB_DATA_W = 16;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Saturating add of a small increment (0..3) to an event counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/emib_ram_array.sv
// Simple dual-port RAM: synchronous write, registered read, write-first bypass on same-address access.
// WIDTH is chosen by the parent (one extra bit when EMIB_RAM_PARITY_EN is defined).
module emib_ram_array #(
  parameter int ADDR_W = 12,
  parameter int WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value between reads; same-edge write wins over stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata <= '0;
    else if (re)
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/emib_ram_responder.sv
// Memory-side responder: zero-fill sweep after reset, 1-clock reads, drop counting during fill.
// EMIB_RAM_PARITY_EN adds a stored even-parity bit per word with error pulse and counter.
import emib_pkg::*;

module emib_ram_responder #(
  parameter int ADDR_W = EMIB_ADDR_W,
  parameter int DATA_W = EMIB_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_init_done,
  output logic [7:0]        o_drop_cnt,
  input  logic              i_err_clr,
  input  logic              i_par_inj,
  output logic              o_par_err,
  output logic [7:0]        o_err_cnt
);

`ifdef EMIB_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              running;
  logic              rd_acc;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [MEM_W-1:0]  arr_wdata;

  assign running = (state == ST_RUN);
  assign rd_acc  = i_rd_en & running;

`ifdef EMIB_RAM_PARITY_EN
  assign wr_word = {(^i_wr_data) ^ i_par_inj, i_wr_data};
`else
  assign wr_word = i_wr_data;
`endif

  // The sweep owns the write port until the fill completes.
  assign arr_we    = running ? i_wr_en : 1'b1;
  assign arr_waddr = running ? i_wr_addr : ptr;
  assign arr_wdata = running ? wr_word : '0;

  emib_ram_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (MEM_W)
  ) u_array (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (rd_acc),
    .raddr (i_rd_addr),
    .rdata (rd_word)
  );

  assign o_rd_data = rd_word[DATA_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_INIT;
      ptr         <= '0;
      o_init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + 1'b1;
      if (&ptr) begin
        state       <= ST_RUN;
        o_init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_valid <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_rd_valid <= rd_acc;
      if (!running)
        o_drop_cnt <= sat_add(o_drop_cnt, {1'b0, i_rd_en} + {1'b0, i_wr_en});
    end
  end

`ifdef EMIB_RAM_PARITY_EN
  logic par_bad;
  // Stored word plus parity bit must XOR to zero for a clean read.
  assign par_bad = o_rd_valid & (^rd_word);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_par_err <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      o_par_err <= par_bad;
      if (i_err_clr)
        o_err_cnt <= '0;
      else if (par_bad)
        o_err_cnt <= sat_add(o_err_cnt, 2'd1);
    end
  end
`else
  logic unused_par;
  assign unused_par = ^{i_par_inj, i_err_clr};
  assign o_par_err  = 1'b0;
  assign o_err_cnt  = '0;
`endif

endmodule
